// File: rtl/encoder_8to3_pending_pkg.sv
`default_nettype none
// =============================================================================
// encoder_8to3_pending_pkg : shared sizes and FSM encoding for the encoder
// Revision : 1.0
// =============================================================================
package encoder_8to3_pending_pkg;

    localparam int ENC_N = 8;
    localparam int ENC_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/encoder_8to3_pending_prio.sv
`default_nettype none
// =============================================================================
// priority_enc_8to3 : combinational highest-bit-first priority encoder
// Revision : 1.0
// =============================================================================
module priority_enc_8to3
    import encoder_8to3_pending_pkg::*;
(
    input  logic [ENC_N-1:0] req_i,
    output logic [ENC_W-1:0] idx_o,
    output logic [ENC_N-1:0] onehot_o,
    output logic             any_o
);

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < ENC_N; i++) begin
            if (req_i[i]) begin
                idx_o       = ENC_W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/encoder_8to3_pending.sv
`default_nettype none
// =============================================================================
// encoder_8to3_pending : accumulates requests, serves one index per handshake
// Revision : 1.0
// =============================================================================
module encoder_8to3_pending
    import encoder_8to3_pending_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [ENC_N-1:0] d_i,
    input  logic             ready_i,
    output logic [ENC_W-1:0] a_o,
    output logic             valid_o,
    output logic [ENC_N-1:0] pend_o,
    output logic             ovf_o
);

    state_e           state_q, state_d;
    logic [ENC_N-1:0] pend_q, pend_d;
    logic [ENC_W-1:0] a_q, a_d;
    logic             ovf_q, ovf_d;

    logic [ENC_W-1:0] prio_idx;
    logic [ENC_N-1:0] prio_onehot;
    logic             prio_any;
    logic             load;
    logic [ENC_N-1:0] load_mask;
    logic [ENC_N-1:0] new_req;

    priority_enc_8to3 u_prio (
        .req_i    (pend_q),
        .idx_o    (prio_idx),
        .onehot_o (prio_onehot),
        .any_o    (prio_any)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (prio_any) begin
                    load    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready_i) begin
                    if (prio_any) load = 1'b1;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) a_d = prio_idx;

        load_mask = load ? prio_onehot : '0;
        new_req   = en_i ? d_i : '0;
        // The bit moving into A this edge counts as in flight, so a hit on it
        // re-pends without flagging overflow.
        pend_d    = (pend_q & ~load_mask) | new_req;
        ovf_d     = ovf_q | (|(new_req & pend_q & ~load_mask));

        if (clr_i) begin
            pend_d  = '0;
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
            a_d     = a_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            a_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            ovf_q   <= ovf_d;
        end
    end

    assign a_o     = a_q;
    assign valid_o = (state_q == ST_HOLD);
    assign pend_o  = pend_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire
